video_pattern_gen: RTL
======================

Name: video_pattern_gen

Overview:
- Video stream source driving the codebase's di/de/hs/vs pixel interface, the input side of the 3x3 filter chain (sobel, median, etc.).
- Produces programmable-size frames of test patterns with configurable horizontal/vertical blanking and optional de gapping.
- Used as the stimulus generator for filter bring-up on hardware and in simulation.

Parameters:
- DE_I_PERIOD, 0, pixel cadence: 0 = de every active clock; N>0 = one de-high clock followed by N de-low gap clocks.
- LINE_SIZE_MAX, 1024, maximum active pixels per line; x_size is clamped to this value.
- DATA_WIDTH, 8, pixel width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = run frames; 0 = stop after the current frame completes
- pattern_sel  in  2  0 = H ramp, 1 = V ramp, 2 = checkerboard, 3 = vertical line (see Optional Feature)
- x_size  in  16  active pixels per line
- y_size  in  16  active lines per frame
- hblank  in  16  horizontal blanking clocks after each line
- vblank  in  16  vertical blanking clocks after the last line's hblank
- do_o  out  DATA_WIDTH  pixel data
- de_o  out  1  pixel valid
- hs_o  out  1  high during horizontal blanking
- vs_o  out  1  high during vertical blanking
- frame_done  out  1  one-clock pulse on the last vblank clock

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; state IDLE; all counters 0.
- All outputs are registered.
- FSM states: IDLE, ACTIVE, GAP, HBLANK, VBLANK.
- IDLE:
  - x_size, y_size, hblank, vblank and pattern_sel are latched into shadow registers.
  - If enable=1, x_size!=0 and y_size!=0, go to ACTIVE; otherwise stay in IDLE.
  - First de_o=1 appears on the clock after enable is sampled high.
- ACTIVE:
  - de_o=1 and do_o=pattern(x,y) for exactly one clock; then x increments.
  - If DE_I_PERIOD>0, go to GAP for DE_I_PERIOD clocks with de_o=0, hs_o=0 and do_o held.
  - After pixel x_size-1 (clamped to LINE_SIZE_MAX), go to HBLANK directly; no trailing GAP.
- HBLANK:
  - hs_o=1 and de_o=0 for max(hblank,1) clocks.
  - Then y increments, x=0.
  - If y was y_size-1, go to VBLANK; else go to ACTIVE.
- VBLANK:
  - vs_o=1, hs_o=0, de_o=0 for max(vblank,1) clocks.
  - frame_done=1 on the final clock.
  - Next state: if enable=1, relatch the shadow registers and go to ACTIVE with no idle clock; else go to IDLE.
- Config inputs are sampled only at frame boundaries; changes mid-frame have no effect.
- enable deasserted mid-frame: the frame finishes including VBLANK, then IDLE. A frame is never truncated.
- Patterns (x, y are 16-bit counters):
  - 0: do_o = x[DATA_WIDTH-1:0] (wraps).
  - 1: do_o = y[DATA_WIDTH-1:0].
  - 2: do_o = all-ones when x[3]^y[3]=1, else 0 (8x8 squares).
  - 3: do_o = all-ones when x == x_size>>1, else 0.
- Per frame: de-high count = x_size*y_size; frame length = y_size*(x_size*(DE_I_PERIOD+1) - DE_I_PERIOD + max(hblank,1)) + max(vblank,1) clocks.
- rst=0 mid-frame: immediate return to the reset state; the next frame starts from x=0, y=0.

Optional Feature:
- Macro: VIDEO_PATTERN_GEN_LFSR_EN.
- Defined: pattern_sel=3 outputs noise.
  - Source is a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
  - The LFSR is reloaded at every frame start and advances only on de_o=1 clocks.
  - do_o = LFSR[DATA_WIDTH-1:0], so every frame is identical.
- Not defined: pattern_sel=3 is the centre vertical line; no LFSR logic is present.

Test Plan:
- Frame geometry: x_size=4, y_size=2, hblank=3, vblank=5, DE_I_PERIOD=0, pattern 0, enable held 1.
  - 8 de pulses; do_o sequence 0,1,2,3,0,1,2,3.
  - hs_o high 3 clocks after each line; vs_o high 5 clocks; frame_done at clock 19.
  - Next frame starts at clock 20.
- Gapped cadence: DE_I_PERIOD=2, x_size=3, y_size=1, hblank=1, vblank=1.
  - de_o pattern 1,0,0,1,0,0,1, then hs_o=1 for 1 clock, then vs_o=1 for 1 clock; 9 clocks total.
- Stop and degenerate sizes:
  - enable dropped after the 2nd de of a 4x2 frame: all 8 pixels and vblank still emitted, then IDLE with outputs 0.
  - x_size=0: stays IDLE, de_o never asserts.
- Checkerboard and clamp: pattern 2, x_size=16, y_size=16; do_o=255 exactly where x[3]^y[3]=1.
  - x_size=2000 yields 1024 de pulses per line.
- Reset: rst=0 asserted mid-line; outputs go to 0 without waiting for a clock edge.
  - After release with enable=1, the first pixel is x=0, y=0 (do_o=0 for pattern 0).
- LFSR build (VIDEO_PATTERN_GEN_LFSR_EN defined): pattern 3, two consecutive 4x4 frames produce identical do_o sequences.
  - The first pixel equals 8'hE1.

Source files
------------

// File: rtl/video_pattern_gen_if.sv
// Pixel-stream bundle for video_pattern_gen: frame configuration in, di/de/hs/vs style video out.
// master = the generator, slave = the consumer/config side.
interface video_pattern_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic [1:0]            pattern_sel;
  logic [15:0]           x_size;
  logic [15:0]           y_size;
  logic [15:0]           hblank;
  logic [15:0]           vblank;
  logic [DATA_WIDTH-1:0] do_o;
  logic                  de_o;
  logic                  hs_o;
  logic                  vs_o;
  logic                  frame_done;

  modport master (
    input  enable, pattern_sel, x_size, y_size, hblank, vblank,
    output do_o, de_o, hs_o, vs_o, frame_done
  );

  modport slave (
    output enable, pattern_sel, x_size, y_size, hblank, vblank,
    input  do_o, de_o, hs_o, vs_o, frame_done
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Test-pattern video source with programmable geometry, blanking and de gapping.
// Build option VIDEO_PATTERN_GEN_LFSR_EN turns pattern 3 into LFSR noise instead of the centre line.
//
// state    | meaning
// S_IDLE   | no frame running; config shadows track the inputs
// S_ACTIVE | de_o=1, one pixel on do_o
// S_GAP    | de-low cadence clocks between pixels of a line
// S_HBLANK | hs_o=1 after each line
// S_VBLANK | vs_o=1 after the last line; frame_done on the final clock
module video_pattern_gen #(
  parameter int DE_I_PERIOD   = 0,
  parameter int LINE_SIZE_MAX = 1024,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  video_pattern_gen_if.master vid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP,
    S_HBLANK,
    S_VBLANK
  } state_t;

  localparam logic [15:0] LMAX     = 16'(LINE_SIZE_MAX);
  localparam int          GAP_INT  = (DE_I_PERIOD > 0) ? DE_I_PERIOD - 1 : 0;
  localparam logic [15:0] GAP_LOAD = 16'(GAP_INT);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  state_t                r_state;
  logic [15:0]           r_x;
  logic [15:0]           r_y;
  logic [15:0]           r_cnt;
  logic [15:0]           r_xs;
  logic [15:0]           r_ys;
  logic [15:0]           r_hb;
  logic [15:0]           r_vb;
  logic [1:0]            r_sel;
  logic [DATA_WIDTH-1:0] r_do;
  logic                  r_de;
  logic                  r_hs;
  logic                  r_vs;
  logic                  r_fd;

  state_t                w_state_nxt;
  logic [15:0]           w_x_nxt;
  logic [15:0]           w_y_nxt;
  logic [15:0]           w_cnt_nxt;
  logic                  w_latch;
  logic                  w_frame_start;
  logic [15:0]           w_xs_in;
  logic                  w_cfg_ok;
  logic [15:0]           w_hb_eff;
  logic [15:0]           w_vb_eff;
  logic [15:0]           w_xs_nxt;
  logic [15:0]           w_ys_nxt;
  logic [15:0]           w_hb_nxt;
  logic [15:0]           w_vb_nxt;
  logic [1:0]            w_sel_nxt;
  logic [DATA_WIDTH-1:0] w_pix;
  logic [DATA_WIDTH-1:0] w_do_nxt;

  assign w_xs_in  = (vid.x_size > LMAX) ? LMAX : vid.x_size;
  assign w_cfg_ok = vid.enable && (vid.x_size != 16'd0) && (vid.y_size != 16'd0);
  assign w_hb_eff = (r_hb == 16'd0) ? 16'd1 : r_hb;
  assign w_vb_eff = (r_vb == 16'd0) ? 16'd1 : r_vb;

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_cnt_nxt     = r_cnt;
    w_latch       = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_latch = 1'b1;
        if (w_cfg_ok) begin
          w_state_nxt   = S_ACTIVE;
          w_x_nxt       = 16'd0;
          w_y_nxt       = 16'd0;
          w_frame_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (r_x == r_xs - 16'd1) begin
          w_state_nxt = S_HBLANK;
          w_cnt_nxt   = w_hb_eff - 16'd1;
        end else begin
          w_x_nxt = r_x + 16'd1;
          if (DE_I_PERIOD > 0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == 16'd0) w_state_nxt = S_ACTIVE;
        else                w_cnt_nxt   = r_cnt - 16'd1;
      end
      S_HBLANK: begin
        if (r_cnt == 16'd0) begin
          w_x_nxt = 16'd0;
          if (r_y == r_ys - 16'd1) begin
            w_state_nxt = S_VBLANK;
            w_y_nxt     = 16'd0;
            w_cnt_nxt   = w_vb_eff - 16'd1;
          end else begin
            w_state_nxt = S_ACTIVE;
            w_y_nxt     = r_y + 16'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_VBLANK: begin
        if (r_cnt == 16'd0) begin
          w_latch = 1'b1;
          if (w_cfg_ok) begin
            w_state_nxt   = S_ACTIVE;
            w_x_nxt       = 16'd0;
            w_y_nxt       = 16'd0;
            w_frame_start = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shadows change only at frame boundaries; the first pixel already uses the new values.
  assign w_xs_nxt  = w_latch ? w_xs_in         : r_xs;
  assign w_ys_nxt  = w_latch ? vid.y_size      : r_ys;
  assign w_hb_nxt  = w_latch ? vid.hblank      : r_hb;
  assign w_vb_nxt  = w_latch ? vid.vblank      : r_vb;
  assign w_sel_nxt = w_latch ? vid.pattern_sel : r_sel;

`ifdef VIDEO_PATTERN_GEN_LFSR_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  // Holds the value on the most recent de clock; stepping on the next pixel gives "advance on de".
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (w_frame_start)
      w_lfsr_nxt = LFSR_SEED;
    else if (w_state_nxt == S_ACTIVE)
      w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lfsr <= 16'd0;
    else      r_lfsr <= w_lfsr_nxt;
  end
`endif

  always_comb begin
    w_pix = '0;
    case (w_sel_nxt)
      2'd0: w_pix = w_x_nxt[DATA_WIDTH-1:0];
      2'd1: w_pix = w_y_nxt[DATA_WIDTH-1:0];
      2'd2: w_pix = {DATA_WIDTH{w_x_nxt[3] ^ w_y_nxt[3]}};
`ifdef VIDEO_PATTERN_GEN_LFSR_EN
      default: w_pix = w_lfsr_nxt[DATA_WIDTH-1:0];
`else
      default: w_pix = {DATA_WIDTH{w_x_nxt == (w_xs_nxt >> 1)}};
`endif
    endcase
  end

  always_comb begin
    w_do_nxt = '0;
    case (w_state_nxt)
      S_ACTIVE: w_do_nxt = w_pix;
      S_GAP:    w_do_nxt = r_do;
      default:  w_do_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_x     <= 16'd0;
      r_y     <= 16'd0;
      r_cnt   <= 16'd0;
      r_xs    <= 16'd0;
      r_ys    <= 16'd0;
      r_hb    <= 16'd0;
      r_vb    <= 16'd0;
      r_sel   <= 2'd0;
      r_do    <= '0;
      r_de    <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_cnt   <= w_cnt_nxt;
      r_xs    <= w_xs_nxt;
      r_ys    <= w_ys_nxt;
      r_hb    <= w_hb_nxt;
      r_vb    <= w_vb_nxt;
      r_sel   <= w_sel_nxt;
      r_do    <= w_do_nxt;
      r_de    <= (w_state_nxt == S_ACTIVE);
      r_hs    <= (w_state_nxt == S_HBLANK);
      r_vs    <= (w_state_nxt == S_VBLANK);
      r_fd    <= (w_state_nxt == S_VBLANK) && (w_cnt_nxt == 16'd0);
    end
  end

  assign vid.do_o       = r_do;
  assign vid.de_o       = r_de;
  assign vid.hs_o       = r_hs;
  assign vid.vs_o       = r_vs;
  assign vid.frame_done = r_fd;

endmodule
